commit_unit: RTL and testbench

//  In-order retirement stage; consumer of the reorder buffer's commit interface.

---
 rtl/fcpu_pkg.sv | 48 ++++
 rtl/commit_unit.sv | 170 +++++++++++++++++
 tb/tb_commit_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fcpu_pkg
//  Brief    : Shared widths, the ROB station entry type, opcode helpers and
//             the commit-stage state type for the fcpu core.
//  Revision : 1.0 - initial release
// ============================================================================
package fcpu_pkg;

    localparam int unsigned RSV_ID_W   = 4;   // ROB entry id width
    localparam int unsigned DATA_W     = 32;  // datapath width
    localparam int unsigned REG_ADDR_W = 6;   // MSB = float-file select, rest = index
    localparam int unsigned INSTR_W    = 6;   // opcode width

    localparam logic [INSTR_W-1:0] OP_NOP    = 6'd0;
    localparam logic [INSTR_W-1:0] OP_ADD    = 6'd1;
    localparam logic [INSTR_W-1:0] OP_SUB    = 6'd2;
    localparam logic [INSTR_W-1:0] OP_LOAD   = 6'd3;
    localparam logic [INSTR_W-1:0] OP_FADD   = 6'd4;
    localparam logic [INSTR_W-1:0] OP_STORE  = 6'd5;
    localparam logic [INSTR_W-1:0] OP_BRANCH = 6'd6;

    typedef struct packed {
        logic [RSV_ID_W-1:0]   station_id;
        logic                  valid;
        logic                  ready;
        logic [REG_ADDR_W-1:0] dst_reg;
        logic [INSTR_W-1:0]    opcode;
        logic [DATA_W-1:0]     content;
    } station_t;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        WAIT_STORE = 1'b1
    } commit_state_t;

    // Stores retire through the store unit handshake.
    function automatic logic op_is_store(input logic [INSTR_W-1:0] opcode);
        return (opcode == OP_STORE);
    endfunction

    // Ops with no architectural destination never touch the register file.
    function automatic logic op_writes_reg(input logic [INSTR_W-1:0] opcode);
        return !((opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_NOP));
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : commit_unit
//  Brief    : In-order retirement stage. Pops the ROB head, writes its result
//             to the integer or float register file and releases committed
//             stores to the store unit. Optional trace port under the
//             COMMIT_TRACE_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
module commit_unit
    import fcpu_pkg::*;
#(
    parameter int unsigned RETIRE_CNT_W  = 32,
    parameter int unsigned STORE_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    i_valid,
    input  station_t                i_commit_data,
    output logic                    i_ready,
    output logic                    rf_we,
    output logic                    rf_fp,
    output logic [REG_ADDR_W-2:0]   rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [RSV_ID_W-1:0]     rf_wtag,
    output logic                    st_commit_valid,
    input  logic                    st_commit_ready,
    input  logic                    rob_clear,
    output logic [RETIRE_CNT_W-1:0] retired_cnt,
    output logic                    err_store_timeout
`ifdef COMMIT_TRACE_EN
    ,
    output logic                    trace_valid,
    output logic [RSV_ID_W-1:0]     trace_rsv_id,
    output logic [INSTR_W-1:0]      trace_opcode,
    output logic [DATA_W-1:0]       trace_data
`endif
);

    commit_state_t             state_q, state_d;
    logic                      ready_d;
    logic                      stv_d;
    logic                      hs_w;
    logic                      writes_w;
    logic                      rf_we_q, rf_fp_q;
    logic [REG_ADDR_W-2:0]     rf_waddr_q;
    logic [DATA_W-1:0]         rf_wdata_q;
    logic [RSV_ID_W-1:0]       rf_wtag_q;
    logic [RETIRE_CNT_W-1:0]   retired_cnt_q;
    logic [31:0]               wait_cnt_q;
    logic                      err_q;

    // Next-state and handshake outputs; a flush in the same cycle blocks acceptance.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        stv_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = nrst & ~rob_clear;
                if (i_valid && ready_d && op_is_store(i_commit_data.opcode)) begin
                    state_d = WAIT_STORE;
                end
            end
            WAIT_STORE: begin
                stv_d = 1'b1;
                if (st_commit_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs_w = i_valid & ready_d;

    // Integer register 0 is hardwired, so writes to it are dropped.
    assign writes_w = op_writes_reg(i_commit_data.opcode) &
                      (i_commit_data.dst_reg[REG_ADDR_W-1] |
                       (i_commit_data.dst_reg[REG_ADDR_W-2:0] != '0));

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Register-file write stage: strobe lasts exactly one cycle per accepted writer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rf_we_q    <= 1'b0;
            rf_fp_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_wtag_q  <= '0;
        end else begin
            rf_we_q <= hs_w & writes_w;
            if (hs_w) begin
                rf_fp_q    <= i_commit_data.dst_reg[REG_ADDR_W-1];
                rf_waddr_q <= i_commit_data.dst_reg[REG_ADDR_W-2:0];
                rf_wdata_q <= i_commit_data.content;
                rf_wtag_q  <= i_commit_data.station_id;
            end
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)     retired_cnt_q <= '0;
        else if (hs_w) retired_cnt_q <= retired_cnt_q + RETIRE_CNT_W'(1);
    end

    // Store-ack watchdog: counts unacknowledged wait cycles, saturates, sets a sticky flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == WAIT_STORE && !st_commit_ready) begin
            if (wait_cnt_q < STORE_TIMEOUT) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
                if (wait_cnt_q + 32'd1 == STORE_TIMEOUT) begin
                    err_q <= 1'b1;
                end
            end
        end else if (state_q == IDLE) begin
            wait_cnt_q <= '0;
        end
    end

`ifdef COMMIT_TRACE_EN
    logic                trace_valid_q;
    logic [RSV_ID_W-1:0] trace_rsv_id_q;
    logic [INSTR_W-1:0]  trace_opcode_q;
    logic [DATA_W-1:0]   trace_data_q;

    // Trace record of every retired entry, one cycle after acceptance.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            trace_valid_q  <= 1'b0;
            trace_rsv_id_q <= '0;
            trace_opcode_q <= '0;
            trace_data_q   <= '0;
        end else begin
            trace_valid_q <= hs_w;
            if (hs_w) begin
                trace_rsv_id_q <= i_commit_data.station_id;
                trace_opcode_q <= i_commit_data.opcode;
                trace_data_q   <= i_commit_data.content;
            end
        end
    end

    assign trace_valid  = trace_valid_q;
    assign trace_rsv_id = trace_rsv_id_q;
    assign trace_opcode = trace_opcode_q;
    assign trace_data   = trace_data_q;
`endif

    assign i_ready           = ready_d;
    assign st_commit_valid   = stv_d;
    assign rf_we             = rf_we_q;
    assign rf_fp             = rf_fp_q;
    assign rf_waddr          = rf_waddr_q;
    assign rf_wdata          = rf_wdata_q;
    assign rf_wtag           = rf_wtag_q;
    assign retired_cnt       = retired_cnt_q;
    assign err_store_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_unit
//  Brief    : Self-checking bench for commit_unit (RETIRE_CNT_W=4,
//             STORE_TIMEOUT=4) with a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_commit_unit;
    import fcpu_pkg::*;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 4;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic                  i_valid;
    station_t              i_commit_data;
    logic                  i_ready;
    logic                  rf_we, rf_fp;
    logic [REG_ADDR_W-2:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [RSV_ID_W-1:0]   rf_wtag;
    logic                  st_commit_valid;
    logic                  st_commit_ready;
    logic                  rob_clear;
    logic [CW-1:0]         retired_cnt;
    logic                  err_store_timeout;
`ifdef COMMIT_TRACE_EN
    logic                  trace_valid;
    logic [RSV_ID_W-1:0]   trace_rsv_id;
    logic [INSTR_W-1:0]    trace_opcode;
    logic [DATA_W-1:0]     trace_data;
`endif

    commit_unit #(.RETIRE_CNT_W(CW), .STORE_TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_commit_data(i_commit_data),
        .i_ready(i_ready), .rf_we(rf_we), .rf_fp(rf_fp), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_wtag(rf_wtag), .st_commit_valid(st_commit_valid),
        .st_commit_ready(st_commit_ready), .rob_clear(rob_clear),
        .retired_cnt(retired_cnt), .err_store_timeout(err_store_timeout)
`ifdef COMMIT_TRACE_EN
        , .trace_valid(trace_valid), .trace_rsv_id(trace_rsv_id),
        .trace_opcode(trace_opcode), .trace_data(trace_data)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state (architectural view of the commit stage)
    bit          m_store_pending;
    bit          m_we;
    bit          m_fp;
    int unsigned m_addr, m_data, m_tag;
    int unsigned m_retired;
    int unsigned m_wait;
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic station_t mk(input logic [INSTR_W-1:0] op, input logic [REG_ADDR_W-1:0] dst,
                                    input logic [DATA_W-1:0] data, input logic [RSV_ID_W-1:0] id);
        station_t s;
        s.station_id = id; s.valid = 1'b1; s.ready = 1'b1;
        s.dst_reg = dst; s.opcode = op; s.content = data;
        return s;
    endfunction

    function automatic bit model_writes(input logic [INSTR_W-1:0] op);
        return !(op == OP_STORE || op == OP_BRANCH || op == OP_NOP);
    endfunction

    task automatic model_reset();
        m_store_pending = 0; m_we = 0; m_fp = 0; m_addr = 0; m_data = 0; m_tag = 0;
        m_retired = 0; m_wait = 0; m_err = 0;
    endtask

    // One clock cycle: drive, check current outputs against the model, advance the model.
    task automatic cyc(input logic v, input station_t d, input logic sr, input logic clr);
        bit exp_rdy;
        i_valid = v; i_commit_data = d; st_commit_ready = sr; rob_clear = clr;
        #1;
        exp_rdy = !m_store_pending && !clr;
        chk("i_ready", i_ready, exp_rdy);
        chk("st_commit_valid", st_commit_valid, m_store_pending);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_fp", rf_fp, m_fp);
            chk("rf_waddr", rf_waddr, m_addr);
            chk("rf_wdata", rf_wdata, m_data);
            chk("rf_wtag", rf_wtag, m_tag);
        end
        chk("retired_cnt", retired_cnt, m_retired);
        chk("err_store_timeout", err_store_timeout, m_err);
        m_we = 0;
        if (m_store_pending) begin
            if (sr) m_store_pending = 0;
            else begin
                m_wait++;
                if (m_wait == TO) m_err = 1;
            end
        end else if (v && exp_rdy) begin
            m_retired = (m_retired + 1) % (1 << CW);
            m_fp   = d.dst_reg[REG_ADDR_W-1];
            m_addr = d.dst_reg[REG_ADDR_W-2:0];
            m_data = d.content;
            m_tag  = d.station_id;
            m_we   = model_writes(d.opcode) && (m_fp || m_addr != 0);
            if (d.opcode == OP_STORE) begin
                m_store_pending = 1;
                m_wait = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    station_t idle_e;
    station_t r;

    initial begin
        idle_e = mk(OP_NOP, '0, '0, '0);
        nrst = 1'b0; i_valid = 0; i_commit_data = idle_e; st_commit_ready = 0; rob_clear = 0;
        model_reset();
        #2;
        // Reset state
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_st_valid", st_commit_valid, 1'b0);
        chk("rst_retired", retired_cnt, '0);
        chk("rst_err", err_store_timeout, 1'b0);
        chk("rst_rf_wdata", rf_wdata, '0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // Back-to-back ALU ops
        cyc(1, mk(OP_ADD, 6'd5, 32'h11, 4'd1), 0, 0);
        cyc(1, mk(OP_SUB, 6'd6, 32'h22, 4'd2), 0, 0);
        cyc(0, idle_e, 0, 0);
        chk("retired_after_two", retired_cnt, 4'd2);

        // Integer dst 0 suppressed; float dst {1,3}
        cyc(1, mk(OP_ADD, 6'd0, 32'hFF, 4'd3), 0, 0);
        cyc(1, mk(OP_FADD, 6'b100011, 32'h3F80_0000, 4'd4), 0, 0);
        cyc(0, idle_e, 0, 0);

        // Store with ack after 3 cycles; the next ALU op waits behind it
        cyc(1, mk(OP_STORE, 6'd7, 32'hDEAD, 4'd5), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, mk(OP_ADD, 6'd8, 32'h88, 4'd6), 0, 0);
        cyc(1, mk(OP_ADD, 6'd8, 32'h88, 4'd6), 1, 0);
        cyc(1, mk(OP_ADD, 6'd8, 32'h88, 4'd6), 0, 0);
        cyc(0, idle_e, 0, 0);

        // Flush while a write is pending: write completes, head refused
        cyc(1, mk(OP_LOAD, 6'd9, 32'h99, 4'd7), 0, 0);
        cyc(1, mk(OP_ADD, 6'd10, 32'hAA, 4'd8), 0, 1);
        cyc(0, idle_e, 0, 0);

        // Store-ack timeout: flag rises after the 4th wait cycle and stays set
        cyc(1, mk(OP_STORE, 6'd1, 32'h1234, 4'd9), 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, idle_e, 0, 0);
        chk("timeout_sticky", err_store_timeout, 1'b1);
        cyc(0, idle_e, 1, 0);
        cyc(1, mk(OP_ADD, 6'd2, 32'h5, 4'd10), 0, 0);

        // Counter wrap: 16 more retires bring the count back to its start value
        for (int i = 0; i < 16; i++) cyc(1, mk(OP_ADD, 6'd3, i, 4'(i)), 0, 0);
        cyc(0, idle_e, 0, 0);

        // Reset in the middle of WAIT_STORE
        cyc(1, mk(OP_STORE, 6'd4, 32'h77, 4'd11), 0, 0);
        cyc(0, idle_e, 0, 0);
        nrst = 1'b0;
        #1;
        chk("midrst_st_valid", st_commit_valid, 1'b0);
        chk("midrst_retired", retired_cnt, '0);
        chk("midrst_i_ready", i_ready, 1'b0);
        chk("midrst_err", err_store_timeout, 1'b0);
        model_reset();
        @(posedge clk); #1;
        nrst = 1'b1;
        cyc(1, mk(OP_ADD, 6'd12, 32'hC0DE, 4'd12), 0, 0);
        cyc(0, idle_e, 0, 0);

        // Randomized traffic, including protocol-error entries and flushes
        for (int i = 0; i < 400; i++) begin
            r = mk(INSTR_W'($urandom_range(0, 7)), REG_ADDR_W'($urandom), $urandom, RSV_ID_W'($urandom));
            r.valid = ($urandom_range(0, 7) != 0);
            r.ready = ($urandom_range(0, 7) != 0);
            cyc(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        end
        cyc(0, idle_e, 1, 0);
        cyc(0, idle_e, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
